// File: rtl/shift_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_scheduler_if
//  Description : Request (two requesters) and response handshake bundle
//                between the operand/control logic and shift_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_scheduler_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_data;
    logic [5:0] req_amt;
    logic [3:0] req_op;
    logic [1:0] req_dir;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_data;

    // Requester side
    modport master (
        output req_valid, req_data, req_amt, req_op, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_data, req_amt, req_op, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : shift_scheduler
//  Description : Round-robin controller sharing one 4-bit rotate shifter
//                between two requesters. Latches the winner's operands,
//                drives the shifter for ISSUE_CYCLES cycles, captures and
//                fixes up the rotated value into a logical/arithmetic shift
//                result, and returns it over a valid/ready response.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_scheduler #(
    parameter int ISSUE_CYCLES = 1   // settle cycles with sh_en high, 1..15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_scheduler_if.slave bus,
    output logic [3:0]       sh_a,
    output logic [1:0]       sh_s,
    output logic             sh_dir,
    output logic             sh_en,
    input  wire logic [3:0]  sh_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST = 4'(ISSUE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_ptr;
    logic [3:0] r_cnt;
    logic       r_sign;     // a[3] of the latched operand, for arithmetic right
    logic [2:0] r_amt;
    logic [1:0] r_op;
    logic       r_dir;
    logic       r_id;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [3:0] r_rsp_data;

    logic       w_any;
    logic       w_gnt_id;
    logic       w_xfer;
    logic       w_last;
    logic [1:0] w_ready;
    logic [3:0] w_sel_data;
    logic [2:0] w_sel_amt;
    logic [1:0] w_sel_op;
    logic       w_sel_dir;
    logic [3:0] w_lo_mask;
    logic [3:0] w_hi_mask;
    logic [3:0] w_fix;

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;

    // Grant selection, request ready and winner operand mux
    always_comb begin
        w_any    = |bus.req_valid;
        w_gnt_id = r_ptr;
        if (bus.req_valid == 2'b01) begin
            w_gnt_id = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            w_gnt_id = 1'b1;
        end
        w_xfer  = (r_state == S_IDLE) && w_any;
        w_ready = 2'b00;
        if (w_xfer && !rst) begin
            w_ready = w_gnt_id ? 2'b10 : 2'b01;
        end
        w_sel_data = w_gnt_id ? bus.req_data[7:4] : bus.req_data[3:0];
        w_sel_amt  = w_gnt_id ? bus.req_amt[5:3]  : bus.req_amt[2:0];
        w_sel_op   = w_gnt_id ? bus.req_op[3:2]   : bus.req_op[1:0];
        w_sel_dir  = w_gnt_id ? bus.req_dir[1]    : bus.req_dir[0];
        w_last     = (r_cnt == C_LAST);
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer)        w_next = S_ISSUE;
            S_ISSUE: if (w_last)        w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Fix-up: turn the raw rotation into logical/arithmetic shift results.
    // The rotator only sees amt[1:0]; amounts of 4..7 are resolved here.
    always_comb begin
        w_lo_mask = 4'b0000;
        w_hi_mask = 4'b0000;
        case (r_amt[1:0])
            2'd1: begin w_lo_mask = 4'b0001; w_hi_mask = 4'b1000; end
            2'd2: begin w_lo_mask = 4'b0011; w_hi_mask = 4'b1100; end
            2'd3: begin w_lo_mask = 4'b0111; w_hi_mask = 4'b1110; end
            default: begin w_lo_mask = 4'b0000; w_hi_mask = 4'b0000; end
        endcase
        w_fix = sh_result;
        if ((r_amt != 3'd0) && ((r_op == 2'b01) || (r_op == 2'b10))) begin
            if (r_dir) begin
                // Logical and arithmetic left behave identically
                w_fix = r_amt[2] ? 4'b0000 : (sh_result & ~w_lo_mask);
            end else if (r_op == 2'b10) begin
                if (r_amt[2]) begin
                    w_fix = {4{r_sign}};
                end else begin
                    w_fix = r_sign ? (sh_result | w_hi_mask)
                                   : (sh_result & ~w_hi_mask);
                end
            end else begin
                w_fix = r_amt[2] ? 4'b0000 : (sh_result & ~w_hi_mask);
            end
        end
    end

    // Operand latch, shifter drive, settle counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 1'b0;
            r_cnt       <= 4'd0;
            r_sign      <= 1'b0;
            r_amt       <= 3'd0;
            r_op        <= 2'b00;
            r_dir       <= 1'b0;
            r_id        <= 1'b0;
            sh_a        <= 4'd0;
            sh_s        <= 2'd0;
            sh_dir      <= 1'b0;
            sh_en       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_sign <= w_sel_data[3];
                        r_amt  <= w_sel_amt;
                        r_op   <= w_sel_op;
                        r_dir  <= w_sel_dir;
                        r_id   <= w_gnt_id;
                        r_ptr  <= ~w_gnt_id;
                        r_cnt  <= 4'd0;
                        sh_a   <= w_sel_data;
                        sh_s   <= w_sel_amt[1:0];
                        sh_dir <= w_sel_dir;
                        sh_en  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_last) begin
                        r_rsp_data  <= w_fix;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        sh_en       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    sh_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_scheduler
//  Description : Directed self-checking bench for shift_scheduler with a
//                behavioural 4-bit rotator standing in for the gate-level
//                shifter. Two instances: ISSUE_CYCLES=1 and ISSUE_CYCLES=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shift_scheduler_if bus1 ();
    shift_scheduler_if bus3 ();

    logic [3:0] sha1, shr1, sha3, shr3;
    logic [1:0] shs1, shs3;
    logic       shd1, she1, shd3, she3;

    // Rotator model: rotate a by s, left when dir=1
    function automatic logic [3:0] rot(input logic [3:0] a, input logic [1:0] s, input logic dir);
        logic [7:0] t;
        if (dir) begin
            t = {a, a} << s;
            return t[7:4];
        end else begin
            t = {a, a} >> s;
            return t[3:0];
        end
    endfunction

    assign shr1 = she1 ? rot(sha1, shs1, shd1) : 4'b0000;
    assign shr3 = she3 ? rot(sha3, shs3, shd3) : 4'b0000;

    shift_scheduler #(.ISSUE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sh_a(sha1), .sh_s(shs1), .sh_dir(shd1), .sh_en(she1), .sh_result(shr1)
    );

    shift_scheduler #(.ISSUE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .sh_a(sha3), .sh_s(shs3), .sh_dir(shd3), .sh_en(she3), .sh_result(shr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against a hung handshake
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the ISSUE_CYCLES=1 instance; starts at a falling edge in IDLE
    task automatic txn1(input logic id, input logic [3:0] d, input logic [2:0] k,
                        input logic [1:0] op, input logic dir, input logic [3:0] exp,
                        input string tag);
        int lat;
        int en;
        if (id) begin
            bus1.req_data[7:4] = d; bus1.req_amt[5:3] = k;
            bus1.req_op[3:2]   = op; bus1.req_dir[1]  = dir;
            bus1.req_valid     = 2'b10;
        end else begin
            bus1.req_data[3:0] = d; bus1.req_amt[2:0] = k;
            bus1.req_op[1:0]   = op; bus1.req_dir[0]  = dir;
            bus1.req_valid     = 2'b01;
        end
        bus1.rsp_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, {6'd0, bus1.req_ready}, id ? 8'h02 : 8'h01);
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after the transfer; the in-flight result must not move
        bus1.req_valid = 2'b00;
        bus1.req_data  = ~bus1.req_data;
        bus1.req_amt   = ~bus1.req_amt;
        bus1.req_op    = ~bus1.req_op;
        bus1.req_dir   = ~bus1.req_dir;
        chk({tag, "_sha"}, {4'd0, sha1}, {4'd0, d});
        lat = 1;
        en  = she1 ? 1 : 0;
        while (!bus1.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (she1) en++;
        end
        chk({tag, "_lat"}, 8'(lat), 8'd2);
        chk({tag, "_en"},  8'(en),  8'd1);
        chk({tag, "_vld"}, {7'd0, bus1.rsp_valid}, 8'h01);
        chk({tag, "_dat"}, {4'd0, bus1.rsp_data}, {4'd0, exp});
        chk({tag, "_id"},  {7'd0, bus1.rsp_id},   {7'd0, id});
        @(negedge clk);
        chk({tag, "_done"}, {7'd0, bus1.rsp_valid}, 8'h00);
    endtask

    initial begin
        int n;
        int lat;
        int en;
        int bad;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus1.req_valid = 2'b11; bus1.req_data = 8'h00; bus1.req_amt = 6'd0;
        bus1.req_op    = 4'd0;  bus1.req_dir  = 2'b00; bus1.rsp_ready = 1'b0;
        bus3.req_valid = 2'b00; bus3.req_data = 8'h00; bus3.req_amt = 6'd0;
        bus3.req_op    = 4'd0;  bus3.req_dir  = 2'b00; bus3.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy",  {6'd0, bus1.req_ready}, 8'h00);
        chk("rst_vld",  {7'd0, bus1.rsp_valid}, 8'h00);
        chk("rst_en",   {7'd0, she1}, 8'h00);
        chk("rst_sha",  {4'd0, sha1}, 8'h00);
        chk("rst_dat",  {4'd0, bus1.rsp_data}, 8'h00);
        bus1.req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        // Requester 0 rotate right by 1
        txn1(1'b0, 4'b1011, 3'd1, 2'b00, 1'b0, 4'b1101, "r0_rotr1");

        // Requester 1 fix-up cases on 1011
        txn1(1'b1, 4'b1011, 3'd2, 2'b01, 1'b1, 4'b1100, "lsl2");
        txn1(1'b1, 4'b1011, 3'd2, 2'b10, 1'b0, 4'b1110, "asr2");
        txn1(1'b1, 4'b1011, 3'd5, 2'b10, 1'b0, 4'b1111, "asr5");
        txn1(1'b1, 4'b1011, 3'd6, 2'b01, 1'b0, 4'b0000, "lsr6");
        txn1(1'b1, 4'b1011, 3'd7, 2'b00, 1'b1, 4'b1101, "rotl7");
        txn1(1'b1, 4'b1011, 3'd4, 2'b11, 1'b0, 4'b1011, "op11_k4");
        txn1(1'b1, 4'b0011, 3'd0, 2'b10, 1'b0, 4'b0011, "asr0");

        // Fairness: both valid continuously, responses accepted at once
        bus1.req_data  = 8'hBB;
        bus1.req_amt   = {3'd1, 3'd1};
        bus1.req_op    = 4'b0000;
        bus1.req_dir   = 2'b00;
        bus1.rsp_ready = 1'b1;
        bus1.req_valid = 2'b11;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!bus1.rsp_valid && n < 20) begin
                if (bus1.req_ready == 2'b11) bad++;
                @(negedge clk);
                n++;
            end
            chk($sformatf("rr_id%0d", i), {7'd0, bus1.rsp_id}, 8'(i % 2));
            chk($sformatf("rr_dat%0d", i), {4'd0, bus1.rsp_data}, 8'h0D);
            if (i == 3) bus1.req_valid = 2'b00;
            @(negedge clk);
        end
        chk("rr_never_11", 8'(bad), 8'd0);

        // Backpressure in RESP
        bus1.req_data  = 8'h0B;
        bus1.req_amt   = 6'd1;
        bus1.req_op    = 4'd0;
        bus1.req_dir   = 2'b00;
        bus1.rsp_ready = 1'b0;
        bus1.req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 2'b00;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_vld0", {7'd0, bus1.rsp_valid}, 8'h01);
        bus1.req_data  = 8'h00;
        bus1.req_op    = 4'b1111;
        bus1.req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_vld%0d", c), {7'd0, bus1.rsp_valid}, 8'h01);
            chk($sformatf("bp_dat%0d", c), {4'd0, bus1.rsp_data}, 8'h0D);
            chk($sformatf("bp_id%0d", c),  {7'd0, bus1.rsp_id}, 8'h00);
            chk($sformatf("bp_rdy%0d", c), {6'd0, bus1.req_ready}, 8'h00);
            chk($sformatf("bp_en%0d", c),  {7'd0, she1}, 8'h00);
        end
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_vld", {7'd0, bus1.rsp_valid}, 8'h00);
        // Pointer now favours requester 1; still in IDLE so ready is combinational
        chk("bp_release_rdy", {6'd0, bus1.req_ready}, 8'h02);
        bus1.req_valid = 2'b00;
        @(negedge clk);

        // Asynchronous reset during ISSUE
        bus1.req_data  = 8'h0B;
        bus1.req_amt   = 6'd1;
        bus1.req_op    = 4'd0;
        bus1.req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 2'b11;
        chk("ar_issue_en", {7'd0, she1}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_en",  {7'd0, she1}, 8'h00);
        chk("ar_sha", {4'd0, sha1}, 8'h00);
        chk("ar_shs", {6'd0, shs1}, 8'h00);
        chk("ar_dat", {4'd0, bus1.rsp_data}, 8'h00);
        chk("ar_rdy", {6'd0, bus1.req_ready}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ptr", {6'd0, bus1.req_ready}, 8'h01);
        bus1.req_valid = 2'b00;
        @(negedge clk);
        chk("ar_noresp", {7'd0, bus1.rsp_valid}, 8'h00);
        txn1(1'b0, 4'b1011, 3'd1, 2'b00, 1'b1, 4'b0111, "ar_after");

        // ISSUE_CYCLES=3 instance: 0110 logical right by 1
        bus3.req_data  = 8'h06;
        bus3.req_amt   = 6'd1;
        bus3.req_op    = 4'b0001;
        bus3.req_dir   = 2'b00;
        bus3.rsp_ready = 1'b1;
        bus3.req_valid = 2'b01;
        #1;
        chk("ic3_rdy", {6'd0, bus3.req_ready}, 8'h01);
        @(posedge clk);
        @(negedge clk);
        bus3.req_valid = 2'b00;
        lat = 1;
        en  = she3 ? 1 : 0;
        while (!bus3.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (she3) en++;
        end
        chk("ic3_en",  8'(en),  8'd3);
        chk("ic3_lat", 8'(lat), 8'd4);
        chk("ic3_dat", {4'd0, bus3.rsp_data}, 8'h03);
        chk("ic3_id",  {7'd0, bus3.rsp_id}, 8'h00);
        @(negedge clk);
        chk("ic3_done", {7'd0, bus3.rsp_valid}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Controller/arbiter that shares one 4-bit rotate shifter (4:1-mux rotator, direction select, active-high output enable) between two requesters.
- Round-robin arbitration; latches the winning operands; drives the shifter for a programmable settle time; captures its output.
- Applies logical/arithmetic fix-up to the captured output and returns the result over a valid/ready response port.
- Sits between the calculator's operand/control logic and the gate-level shifter.

Parameters:
- ISSUE_CYCLES, 1, cycles sh_en is held before capture (gate-level settle margin); legal 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i].
- req_data  input  8  operands; requester i at [4i+3:4i].
- req_amt  input  6  shift amount 0..7; requester i at [3i+2:3i].
- req_op  input  4  op; requester i at [2i+1:2i]. 00 rotate, 01 logical shift, 10 arithmetic shift, 11 treated as rotate.
- req_dir  input  2  per requester: 0 right, 1 left.
- sh_a  output  4  shifter data input.
- sh_s  output  2  shifter amount select.
- sh_dir  output  1  shifter direction (0 right, 1 left).
- sh_en  output  1  shifter output enable; shifter output is 0 when low.
- sh_result  input  4  shifter output (combinational from sh_* ports).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  1  requester index owning the response.
- rsp_data  output  4  final result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, priority pointer=0, settle counter=0.
  - All outputs 0: sh_a, sh_s, sh_dir, sh_en, rsp_valid, rsp_id, rsp_data.
  - req_ready=00.
  - Reset mid-operation aborts the transaction; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational: only the grant winner's bit is 1; all others 0. If no request is valid, req_ready=00.
  - Grant: if only one req_valid is set, that requester wins. If both are set, the requester equal to the pointer wins.
  - On transfer: latch data/amt/op/dir and id; pointer <= ~id; go to ISSUE.
- ISSUE:
  - Registered outputs: sh_a=data, sh_s=amt[1:0], sh_dir=dir, sh_en=1.
  - Counter counts ISSUE_CYCLES cycles.
  - On the last ISSUE cycle's edge: rsp_data <= fixup(sh_result), rsp_id <= id, rsp_valid <= 1, sh_en <= 0, go to RESP.
  - sh_en is low in every state except ISSUE.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in the RESP cycle itself.
- Latency: request accepted at edge k -> rsp_valid high from the cycle after edge k+ISSUE_CYCLES. Minimum is 2 cycles after the accept cycle when rsp_ready=1.
- Throughput: one transaction per ISSUE_CYCLES+2 cycles.
- Fix-up (k = amt, r = sh_result, a = latched data):
  - Rotate: r. This is rotation by k mod 4; k=4 returns a.
  - Logical left, k<4: r with bits [k-1:0] zeroed.
  - Logical right, k<4: r with bits [3:4-k] zeroed.
  - Arithmetic right, k<4: r with bits [3:4-k] = a[3].
  - Arithmetic left: same as logical left.
  - k=0: r unchanged for all ops.
  - k>=4: logical (and arithmetic left) -> 0000; arithmetic right -> {4{a[3]}}.
- Requester inputs are sampled only on the transfer edge. Changes in later cycles do not affect the transaction in flight.
- A requester may hold req_valid across transactions. Fairness: with both valid continuously, grants alternate 0,1,0,1...

Test Plan:
- Reset then requester 0 sends data=1011, op=00, dir=0, amt=1 -> rsp_data=1101, rsp_id=0; sh_en=1 for exactly ISSUE_CYCLES cycles; rsp_valid 2 cycles after accept (ISSUE_CYCLES=1).
- Requester 1 sends data=1011: op=01/dir=1/amt=2 -> 1100; op=10/dir=0/amt=2 -> 1110; op=10/dir=0/amt=5 -> 1111; op=01/dir=0/amt=6 -> 0000; op=00/dir=1/amt=7 -> 1101.
- Both req_valid held high for 4 transactions, rsp_ready=1 -> rsp_id sequence 0,1,0,1; req_ready is never 11.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable; req_ready=00; sh_en=0; operands changed meanwhile do not alter rsp_data.
- Assert rst during ISSUE -> all outputs 0 immediately (async); pointer=0; no response; next request completes normally.
- ISSUE_CYCLES=3, data=0110 logical right by 1 -> sh_en high 3 cycles; rsp_data=0011; rsp_valid 4 cycles after accept.
